alu_arbiter: RTL and testbench
==============================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter FAIR, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with requester 0 winning.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req0_valid  in  1  requester 0 has an operation pending.
REQ-005 req0_ready  out  1  requester 0 operation accepted this cycle.
REQ-006 req0_scra, req0_scrb  in  32 each  requester 0 operands.
REQ-007 req0_ctrl  in  4  requester 0 ALU control code.
REQ-008 req1_valid, req1_ready, req1_scra, req1_scrb, req1_ctrl  same directions and widths as requester 0, for requester 1.
REQ-009 alu_scra, alu_scrb  out  32 each  operands to the shared ALU instance.
REQ-010 alu_control  out  4  control code to the shared ALU.
REQ-011 alu_result  in  32  ALU result.
REQ-012 alu_zero  in  1  ALU compare/flag output.
REQ-013 rsp_valid  out  1  response available.
REQ-014 rsp_ready  in  1  consumer accepts response.
REQ-015 rsp_id  out  1  requester index owning the response.
REQ-016 rsp_result  out  32  cleaned ALU result.
REQ-017 rsp_zero  out  1  cleaned flag.
REQ-018 rsp_err  out  1  control code was illegal (1110 or 1111).

Function
REQ-019 The FSM SHALL have states IDLE, EXEC and RESP, and reset SHALL put it in IDLE.
REQ-020 In IDLE, if either valid is high, exactly one reqN_ready SHALL be high combinationally; on that edge the operands, ctrl and the id SHALL be latched and the FSM SHALL go to EXEC.
REQ-021 In IDLE with no valid, the FSM SHALL stay in IDLE with both readies low.
REQ-022 In EXEC and RESP, both readies SHALL be low.
REQ-023 With FAIR=1 and both valid, the grant SHALL go to the requester other than last_grant; with a single valid, that requester SHALL be granted; last_grant SHALL update on every accept.
REQ-024 With FAIR=0, requester 0 SHALL win whenever req0_valid is high.
REQ-025 alu_scra, alu_scrb and alu_control SHALL always be driven from the latched operand registers, never directly from the request ports.
REQ-026 In EXEC, the ALU outputs SHALL be captured into the response registers and the FSM SHALL go to RESP.
REQ-027 Cleanup on capture, by control code:
- 0000-0100 and 0111-1001: rsp_result = alu_result, rsp_zero = 0.
- 0101-0110: rsp_result = alu_result, rsp_zero = alu_zero.
- 1010-1101: rsp_result = 0, rsp_zero = alu_zero.
- 1110-1111: rsp_result = 0, rsp_zero = 0, rsp_err = 1.
- Otherwise rsp_err = 0.
REQ-028 In RESP, rsp_valid SHALL be 1; the response fields SHALL be held stable until rsp_ready is high, after which the FSM SHALL go to IDLE on that edge.
REQ-029 Latency: for an accept at edge N, rsp_valid SHALL be high from edge N+2; minimum spacing between accepts is 3 cycles with rsp_ready held high.
REQ-030 rsp_valid SHALL be 0 in IDLE and EXEC.
REQ-031 No output SHALL ever carry X, regardless of the ALU's X outputs.

Reset
REQ-032 When rst_n is asserted, the following SHALL be cleared immediately, independent of clk:
- FSM to IDLE.
- rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, readies and operand registers to 0.
- last_grant to 1, so requester 0 wins the first tie.
REQ-033 If reset is asserted mid-operation (EXEC or RESP), the in-flight transaction SHALL be discarded with no response issued after release.
REQ-034 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-035 The bench SHALL cover these scenarios:
- Add: req0 with scra=5, scrb=7, ctrl=0000 and rsp_ready=1 -> at N+2, rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0, rsp_err=0.
- Round-robin, FAIR=1: both valid continuously after reset -> grants in order 0, 1, 0, 1; FAIR=0 -> grants 0, 0, 0.
- Branch compare: req1 with scra=scrb=32'h80000000, ctrl=1010 -> rsp_id=1, rsp_result=0, rsp_zero=1; same with ctrl=1100, scra=-1, scrb=1 -> rsp_zero=0.
- Illegal code: ctrl=1111 -> rsp_err=1, rsp_result=0, rsp_zero=0, with no X on any output.
- Backpressure: rsp_ready low for 5 cycles in RESP -> response stable, both readies low, next accept only after the rsp_ready handshake.
- Mid-op reset: rst_n pulsed low while in EXEC -> outputs 0 immediately, no rsp_valid afterwards, next tie granted to req0.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one ALU between two requesters.
// A three-state FSM (IDLE -> EXEC -> RESP) grants one request, latches its
// operands into the registers that feed the ALU, captures and cleans the
// ALU result, then holds the response until the consumer accepts it.
module alu_arbiter #(
  parameter int FAIR = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_scra,
  input  logic [31:0] req0_scrb,
  input  logic [3:0]  req0_ctrl,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_scra,
  input  logic [31:0] req1_scrb,
  input  logic [3:0]  req1_ctrl,
  output logic [31:0] alu_scra,
  output logic [31:0] alu_scrb,
  output logic [3:0]  alu_control,
  input  logic [31:0] alu_result,
  input  logic        alu_zero,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_result,
  output logic        rsp_zero,
  output logic        rsp_err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]  state;
  logic        last_grant;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [3:0]  op_ctrl;
  logic        op_id;

  logic        grant_any;
  logic        grant_id;
  logic [31:0] clean_result;
  logic        clean_zero;
  logic        clean_err;

  // Pick the winner: round-robin on a tie when FAIR, otherwise requester 0 first.
  always_comb begin
    grant_any = req0_valid | req1_valid;
    grant_id  = ~req0_valid;
    if (FAIR != 0) begin
      if (req0_valid && req1_valid) begin
        grant_id = ~last_grant;
      end
    end
  end

  // Readies are only offered in IDLE, and are forced low while reset is held.
  assign req0_ready = rst_n & (state == IDLE) & grant_any & ~grant_id;
  assign req1_ready = rst_n & (state == IDLE) & grant_any &  grant_id;

  // The ALU only ever sees the latched operands, never the request ports.
  assign alu_scra    = op_a;
  assign alu_scrb    = op_b;
  assign alu_control = op_ctrl;

  assign rsp_valid = (state == RESP);

  // Keep only the ALU outputs that are meaningful for the latched control code,
  // so unused (possibly unknown) ALU outputs never reach the response.
  always_comb begin
    clean_result = 32'd0;
    clean_zero   = 1'b0;
    clean_err    = 1'b0;
    case (op_ctrl)
      4'b0000, 4'b0001, 4'b0010, 4'b0011, 4'b0100,
      4'b0111, 4'b1000, 4'b1001: begin
        clean_result = alu_result;
      end
      4'b0101, 4'b0110: begin
        clean_result = alu_result;
        clean_zero   = alu_zero;
      end
      4'b1010, 4'b1011, 4'b1100, 4'b1101: begin
        clean_zero = alu_zero;
      end
      default: begin
        clean_err = 1'b1;
      end
    endcase
  end

  // FSM, operand latch and response capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_a       <= '0;
      op_b       <= '0;
      op_ctrl    <= '0;
      op_id      <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            op_a       <= grant_id ? req1_scra : req0_scra;
            op_b       <= grant_id ? req1_scrb : req0_scrb;
            op_ctrl    <= grant_id ? req1_ctrl : req0_ctrl;
            op_id      <= grant_id;
            last_grant <= grant_id;
            state      <= EXEC;
          end
        end
        EXEC: begin
          rsp_id     <= op_id;
          rsp_result <= clean_result;
          rsp_zero   <= clean_zero;
          rsp_err    <= clean_err;
          state      <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: randomized and directed checks of alu_arbiter against a
// transaction-level model (grant choice plus result cleanup table).
module tb_alu_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_scra, req0_scrb, req1_scra, req1_scrb;
  logic [3:0]  req0_ctrl, req1_ctrl;
  logic [31:0] alu_scra, alu_scrb, alu_result, alu_raw;
  logic [3:0]  alu_control;
  logic        alu_zero;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [31:0] rsp_result;

  logic        f_req0_valid, f_req0_ready, f_req1_valid, f_req1_ready;
  logic [31:0] f_alu_scra, f_alu_scrb, f_alu_result;
  logic [3:0]  f_alu_control;
  logic        f_alu_zero;
  logic        f_rsp_valid, f_rsp_ready, f_rsp_id, f_rsp_zero, f_rsp_err;
  logic [31:0] f_rsp_result;

  int vectors = 0;
  int miscompares = 0;
  logic model_last;

  alu_arbiter #(.FAIR(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_scra(req0_scra),
    .req0_scrb(req0_scrb), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_scra(req1_scra),
    .req1_scrb(req1_scrb), .req1_ctrl(req1_ctrl),
    .alu_scra(alu_scra), .alu_scrb(alu_scrb), .alu_control(alu_control),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  alu_arbiter #(.FAIR(0)) dut_fixed (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f_req0_valid), .req0_ready(f_req0_ready), .req0_scra(32'd3),
    .req0_scrb(32'd4), .req0_ctrl(4'b0000),
    .req1_valid(f_req1_valid), .req1_ready(f_req1_ready), .req1_scra(32'd9),
    .req1_scrb(32'd1), .req1_ctrl(4'b0001),
    .alu_scra(f_alu_scra), .alu_scrb(f_alu_scrb), .alu_control(f_alu_control),
    .alu_result(f_alu_result), .alu_zero(f_alu_zero),
    .rsp_valid(f_rsp_valid), .rsp_ready(f_rsp_ready), .rsp_id(f_rsp_id),
    .rsp_result(f_rsp_result), .rsp_zero(f_rsp_zero), .rsp_err(f_rsp_err)
  );

  // Behavioural ALU used by both instances.
  function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    case (c)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'd6: return (a < b) ? 32'd1 : 32'd0;
      4'd7: return a << b[4:0];
      4'd8: return a >> b[4:0];
      4'd9: return $unsigned($signed(a) >>> b[4:0]);
      default: return a - b;
    endcase
  endfunction

  // Expected {result, zero, err} straight from the cleanup table.
  function automatic logic [33:0] model_rsp(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    logic z;
    r = alu_fn(c, a, b);
    z = (r == 32'd0);
    if (c <= 4'd4 || (c >= 4'd7 && c <= 4'd9)) return {r, 1'b0, 1'b0};
    if (c == 4'd5 || c == 4'd6) return {r, z, 1'b0};
    if (c >= 4'd10 && c <= 4'd13) return {32'd0, z, 1'b0};
    return {32'd0, 1'b0, 1'b1};
  endfunction

  function automatic logic exp_grant(input logic v0, input logic v1, input logic last);
    if (v0 && v1) return ~last;
    return v1 && !v0;
  endfunction

  // ALU outputs that the cleanup must discard are driven unknown.
  assign alu_raw = alu_fn(alu_control, alu_scra, alu_scrb);
  always_comb begin
    alu_result = alu_raw;
    alu_zero   = (alu_raw == 32'd0);
    if (alu_control >= 4'd10) alu_result = 'x;
    if (!(alu_control == 4'd5 || alu_control == 4'd6 || (alu_control >= 4'd10 && alu_control <= 4'd13)))
      alu_zero = 'x;
  end
  assign f_alu_result = alu_fn(f_alu_control, f_alu_scra, f_alu_scrb);
  assign f_alu_zero   = (f_alu_result == 32'd0);

  task automatic apply_reset();
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_last = 1'b1;
  endtask

  // One full transaction with rsp_ready high; returns what was observed.
  task automatic run_txn(input logic v0, input logic v1,
                         input logic [31:0] a0, input logic [31:0] b0, input logic [3:0] c0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic [3:0] c1,
                         output logic [1:0] rdy, output logic [2:0] exec_obs,
                         output logic resp_valid, output logic [34:0] rsp);
    req0_valid = v0; req0_scra = a0; req0_scrb = b0; req0_ctrl = c0;
    req1_valid = v1; req1_scra = a1; req1_scrb = b1; req1_ctrl = c1;
    #1;
    rdy = {req0_ready, req1_ready};
    @(posedge clk); #1;
    exec_obs = {rsp_valid, req0_ready, req1_ready};
    @(posedge clk); #1;
    resp_valid = rsp_valid;
    rsp = {rsp_id, rsp_result, rsp_zero, rsp_err};
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #3;
    vectors++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, alu_scra, alu_scrb, alu_control} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got rdy=%b%b v=%b id=%b res=%h z=%b e=%b a=%h b=%h c=%h, want all zero",
               req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, alu_scra, alu_scrb, alu_control);
    end
    apply_reset();
  endtask

  // First accept right on the first edge after release: 5 + 7.
  task automatic test_add();
    logic [1:0] rdy; logic [2:0] ex; logic rv; logic [34:0] rsp;
    run_txn(1'b1, 1'b0, 32'd5, 32'd7, 4'b0000, 32'd0, 32'd0, 4'b0000, rdy, ex, rv, rsp);
    model_last = 1'b0;
    vectors++;
    if ({rdy, ex, rv, rsp} !== {2'b10, 3'b000, 1'b1, 1'b0, 32'd12, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL add: got rdy=%b exec=%b rv=%b rsp=%h, want rdy=10 exec=000 rv=1 id=0 res=12 z=0 e=0", rdy, ex, rv, rsp);
    end
  endtask

  task automatic test_round_robin();
    logic [1:0] rdy; logic [2:0] ex; logic rv; logic [34:0] rsp;
    logic [31:0] a0, a1;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      a0 = $urandom; a1 = $urandom;
      run_txn(1'b1, 1'b1, a0, 32'd1, 4'b0000, a1, 32'd2, 4'b0011, rdy, ex, rv, rsp);
      vectors++;
      if ({rdy, ex, rv, rsp[34]} !== {(i % 2 == 0) ? 2'b10 : 2'b01, 3'b000, 1'b1, (i % 2 == 1)}) begin
        miscompares++;
        $display("FAIL round_robin[%0d]: got rdy=%b exec=%b rv=%b id=%b, want grant %0d", i, rdy, ex, rv, rsp[34], i % 2);
      end
    end
    model_last = 1'b1;
  endtask

  task automatic test_fixed_priority();
    apply_reset();
    f_rsp_ready = 1'b1;
    f_req0_valid = 1'b1; f_req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++;
      if ({f_req0_ready, f_req1_ready} !== 2'b10) begin
        miscompares++;
        $display("FAIL fixed_priority[%0d]: got rdy=%b%b, want 10", i, f_req0_ready, f_req1_ready);
      end
      @(posedge clk); @(posedge clk); #1;
      vectors++;
      if ({f_rsp_valid, f_rsp_id, f_rsp_result} !== {1'b1, 1'b0, 32'd7}) begin
        miscompares++;
        $display("FAIL fixed_rsp[%0d]: got v=%b id=%b res=%h, want v=1 id=0 res=7", i, f_rsp_valid, f_rsp_id, f_rsp_result);
      end
      @(posedge clk);
    end
    f_req0_valid = 1'b0;
    #1;
    vectors++;
    if ({f_req0_ready, f_req1_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL fixed_single1: got rdy=%b%b, want 01", f_req0_ready, f_req1_ready);
    end
    f_req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_branch();
    logic [1:0] rdy; logic [2:0] ex; logic rv; logic [34:0] rsp;
    run_txn(1'b0, 1'b1, 32'd0, 32'd0, 4'b0000, 32'h8000_0000, 32'h8000_0000, 4'b1010, rdy, ex, rv, rsp);
    model_last = 1'b1;
    vectors++;
    if ({rdy, rv, rsp} !== {2'b01, 1'b1, 1'b1, 32'd0, 1'b1, 1'b0}) begin
      miscompares++;
      $display("FAIL branch_eq: got rdy=%b rv=%b rsp=%h, want rdy=01 id=1 res=0 z=1 e=0", rdy, rv, rsp);
    end
    run_txn(1'b0, 1'b1, 32'd0, 32'd0, 4'b0000, 32'hFFFF_FFFF, 32'd1, 4'b1100, rdy, ex, rv, rsp);
    vectors++;
    if ({rdy, rv, rsp} !== {2'b01, 1'b1, 1'b1, 32'd0, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL branch_lt: got rdy=%b rv=%b rsp=%h, want rdy=01 id=1 res=0 z=0 e=0", rdy, rv, rsp);
    end
  endtask

  task automatic test_illegal();
    logic [1:0] rdy; logic [2:0] ex; logic rv; logic [34:0] rsp;
    req0_valid = 1'b1; req0_scra = $urandom; req0_scrb = $urandom; req0_ctrl = 4'b1111;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if ($isunknown({req0_ready, req1_ready, alu_scra, alu_scrb, alu_control, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err})) begin
      miscompares++;
      $display("FAIL illegal_no_x: got res=%h z=%b e=%b id=%b, want no unknown bits", rsp_result, rsp_zero, rsp_err, rsp_id);
    end
    @(posedge clk); #1;
    model_last = 1'b0;
    run_txn(1'b1, 1'b0, 32'd1, 32'd1, 4'b1110, 32'd0, 32'd0, 4'b0000, rdy, ex, rv, rsp);
    vectors++;
    if ({rv, rsp} !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b1}) begin
      miscompares++;
      $display("FAIL illegal_1110: got rv=%b rsp=%h, want rv=1 id=0 res=0 z=0 e=1", rv, rsp);
    end
  endtask

  task automatic test_backpressure();
    logic [34:0] want;
    logic g;
    want = {1'b0, 32'd70, 1'b0, 1'b0};
    rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_scra = 32'd100; req0_scrb = 32'd30; req0_ctrl = 4'b0001;
    @(posedge clk); #1;
    model_last = 1'b0;
    req1_valid = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      vectors++;
      if ({rsp_valid, req0_ready, req1_ready, rsp_id, rsp_result, rsp_zero, rsp_err} !== {3'b100, want}) begin
        miscompares++;
        $display("FAIL backpressure_hold[%0d]: got v=%b rdy=%b%b rsp=%h, want v=1 rdy=00 rsp=%h",
                 i, rsp_valid, req0_ready, req1_ready, {rsp_id, rsp_result, rsp_zero, rsp_err}, want);
      end
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    g = exp_grant(1'b1, 1'b1, model_last);
    vectors++;
    if ({rsp_valid, req0_ready, req1_ready} !== {1'b0, ~g, g}) begin
      miscompares++;
      $display("FAIL backpressure_release: got v=%b rdy=%b%b, want v=0 grant %0d", rsp_valid, req0_ready, req1_ready, g);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mid_reset();
    logic [1:0] rdy; logic [2:0] ex; logic rv; logic [34:0] rsp;
    int seen;
    req0_valid = 1'b1; req0_scra = 32'd11; req0_scrb = 32'd22; req0_ctrl = 4'b0000;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, alu_scra, alu_scrb, alu_control} !== '0) begin
      miscompares++;
      $display("FAIL mid_reset_clear: got v=%b a=%h b=%h c=%h res=%h rdy=%b%b, want all zero",
               rsp_valid, alu_scra, alu_scrb, alu_control, rsp_result, req0_ready, req1_ready);
    end
    apply_reset();
    seen = 0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL mid_reset_no_rsp: got %0d cycles with rsp_valid, want 0", seen);
    end
    run_txn(1'b1, 1'b1, 32'd2, 32'd2, 4'b0000, 32'd5, 32'd5, 4'b0000, rdy, ex, rv, rsp);
    model_last = 1'b0;
    vectors++;
    if ({rdy, rsp[34]} !== 3'b100) begin
      miscompares++;
      $display("FAIL mid_reset_tie: got rdy=%b id=%b, want rdy=10 id=0", rdy, rsp[34]);
    end
  endtask

  task automatic test_random();
    logic [1:0] rdy; logic [2:0] ex; logic rv; logic [34:0] rsp;
    logic v0, v1, g;
    logic [31:0] a0, b0, a1, b1;
    logic [3:0] c0, c1;
    logic [34:0] want;
    for (int i = 0; i < 40; i++) begin
      {v0, v1} = 2'($urandom_range(1, 3));
      a0 = $urandom; a1 = $urandom;
      b0 = ($urandom_range(0, 3) == 0) ? a0 : $urandom;
      b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
      c0 = 4'($urandom_range(0, 15)); c1 = 4'($urandom_range(0, 15));
      g = exp_grant(v0, v1, model_last);
      want = g ? {1'b1, model_rsp(c1, a1, b1)} : {1'b0, model_rsp(c0, a0, b0)};
      run_txn(v0, v1, a0, b0, c0, a1, b1, c1, rdy, ex, rv, rsp);
      model_last = g;
      vectors++;
      if ({rdy, ex, rv, rsp} !== {~g, g, 3'b000, 1'b1, want}) begin
        miscompares++;
        $display("FAIL random[%0d]: v=%b%b c=%h/%h got rdy=%b exec=%b rv=%b rsp=%h, want grant %0d rsp=%h",
                 i, v0, v1, c0, c1, rdy, ex, rv, rsp, g, want);
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    rsp_ready = 1'b1; f_rsp_ready = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_scra = '0; req0_scrb = '0; req0_ctrl = '0;
    req1_scra = '0; req1_scrb = '0; req1_ctrl = '0;
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    model_last = 1'b1;
    test_reset();
    test_add();
    test_round_robin();
    test_fixed_priority();
    test_branch();
    test_illegal();
    test_backpressure();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
